// File: rtl/pipelined_decoder.sv
// Purpose   : binary-index decoder (one-hot, optional thermometer) behind a 2-entry OUT/SKID pipeline.
// Latency   : 1 cycle from accept to valid_o when the pipeline is empty.
// Backpressure: ready_o drops only while SKID is full; it is a registered state bit with no path from ready_i.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   valid_i/ready_o upstream handshake; data_i = binary index, mode_i = 0 one-hot / 1 thermometer
//   valid_o/ready_i downstream handshake; data_o = decoded word (all zeros while valid_o = 0)
//   count_o         accepted-request counter, wraps silently
//
// Build option: define DECODER_THERMO_EN to enable thermometer decode selected by mode_i.
// Without it mode_i is ignored and only one-hot decode exists.
module pipelined_decoder #(
    parameter int InputSize  = 5,
    parameter int CountWidth = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_i,
    input  logic [InputSize-1:0]      data_i,
    input  logic                      mode_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic [(1<<InputSize)-1:0] data_o,
    input  logic                      ready_i,
    output logic [CountWidth-1:0]     count_o
);

    localparam int OutWidth = 1 << InputSize;

    // A pending request as held in SKID: the raw index plus, when enabled, its mode.
    // Keeping the undecoded form in SKID means only OUT carries the wide word.
    typedef struct packed {
        logic [InputSize-1:0] idx;
`ifdef DECODER_THERMO_EN
        logic                 thermo;
`endif
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    entry_t skidEntry;
    entry_t inEntry;
    logic   accept;
    logic   transfer;

    always_comb begin
        inEntry     = '0;
        inEntry.idx = data_i;
`ifdef DECODER_THERMO_EN
        inEntry.thermo = mode_i;
`endif
    end

`ifndef DECODER_THERMO_EN
    // mode_i has no function in the one-hot-only build.
    logic unusedMode;
    assign unusedMode = mode_i;
`endif

    function automatic logic [OutWidth-1:0] decode(input entry_t e);
        logic [OutWidth-1:0] oneHot;
        oneHot = {{(OutWidth-1){1'b0}}, 1'b1} << e.idx;
`ifdef DECODER_THERMO_EN
        // Thermometer = (oneHot << 1) - 1; for the top index the shift
        // overflows to zero and the subtraction yields all ones.
        if (e.thermo) begin
            return (oneHot << 1) - OutWidth'(1);
        end
`endif
        return oneHot;
    endfunction

    assign accept   = valid_i && ready_o;
    assign transfer = valid_o && ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            skidEntry <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            ready_o   <= 1'b1;
            count_o   <= '0;
        end else begin
            if (accept) begin
                count_o <= count_o + CountWidth'(1);
            end

            case (state)
                EMPTY: begin
                    if (accept) begin
                        data_o  <= decode(inEntry);
                        valid_o <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && transfer) begin
                        data_o <= decode(inEntry);
                    end else if (accept) begin
                        // OUT is stalled: park the new request, stop accepting.
                        skidEntry <= inEntry;
                        ready_o   <= 1'b0;
                        state     <= TWO;
                    end else if (transfer) begin
                        data_o  <= '0;
                        valid_o <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                TWO: begin
                    // ready_o is low here, so accept cannot occur.
                    if (transfer) begin
                        data_o    <= decode(skidEntry);
                        skidEntry <= '0;
                        ready_o   <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    skidEntry <= '0;
                    data_o    <= '0;
                    valid_o   <= 1'b0;
                    ready_o   <= 1'b1;
                end
            endcase
        end
    end

endmodule
